// File: rtl/lbm_pkg.sv
// ============================================================================
// Module      : lbm_pkg
// Description : Shared definitions for the D2Q9 lattice-Boltzmann streaming
//               address generator: direction count, direction-slot indices,
//               coordinate types and the periodic single-step wrap helper.
// Config      : none (BOUNCEBACK_EN is consumed by stream_dir_addr)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbm_pkg;

    // Number of lattice directions in D2Q9.
    localparam int Q = 9;

    // Default grid geometry; the top module re-derives these from its own
    // parameters, these only size the package-level coordinate type.
    localparam int GRID_DIM_DEF  = 256;
    localparam int ADDRESS_WIDTH = $clog2(GRID_DIM_DEF) + 1;

    // Direction-slot indices. Row 0 is the north edge, so +cy points south.
    // The slots are independent; these names only document the usual layout.
    localparam int DIR_SE   = 0;   // (+1,+1)
    localparam int DIR_SW   = 1;   // (-1,+1)
    localparam int DIR_NW   = 2;   // (-1,-1)
    localparam int DIR_NE   = 3;   // (+1,-1)
    localparam int DIR_S    = 4;   // ( 0,+1)
    localparam int DIR_W    = 5;   // (-1, 0)
    localparam int DIR_N    = 6;   // ( 0,-1)
    localparam int DIR_E    = 7;   // (+1, 0)
    localparam int DIR_REST = 8;   // ( 0, 0)

    // Signed coordinate at the default address width.
    typedef logic signed [ADDRESS_WIDTH-1:0] coord_t;

    // Wide signed working type. Sums are sign-extended into this so the
    // wrap and linearisation arithmetic never overflows for any legal width.
    localparam int WIDE_W = 32;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Single periodic wrap step: valid while |velocity| <= side.
    function automatic wide_t wrap_coord(input wide_t d, input wide_t side);
        wide_t r;
        r = d;
        if (d < 0) begin
            r = d + side;
        end else if (d >= side) begin
            r = d - side;
        end
        return r;
    endfunction

    // True when a coordinate lies inside 0..side-1.
    function automatic logic in_grid(input wide_t d, input wide_t side);
        return (d >= 0) && (d < side);
    endfunction

endpackage : lbm_pkg

`default_nettype wire

// File: rtl/stream_dir_addr.sv
// ============================================================================
// Module      : stream_dir_addr
// Description : Combinational destination-address computation for one
//               streaming direction: coordinate sum, periodic wrap (or wall
//               detection when BOUNCEBACK_EN is defined) and linearisation.
// Config      : BOUNCEBACK_EN - solid walls, out-of-grid moves return the
//               source address and raise wall_o.
// Ports       : x_i, y_i    source cell coordinates (signed, AW bits)
//               cx_i, cy_i  velocity components for this slot (-1/0/+1)
//               addr_o      linear destination address (unsigned, AW bits)
//               wall_o      move left the grid (always 0 without bounceback)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_dir_addr
    import lbm_pkg::*;
#(
    parameter int SIDE_LENGTH = 16,
    parameter int AW          = 9
) (
    input  logic signed [AW-1:0] x_i,
    input  logic signed [AW-1:0] y_i,
    input  logic signed [AW-1:0] cx_i,
    input  logic signed [AW-1:0] cy_i,
    output logic        [AW-1:0] addr_o,
    output logic                 wall_o
);

    localparam wide_t SIDE_W = wide_t'(SIDE_LENGTH);

    // Sums are formed one bit wider than the inputs so that e.g. x=max
    // plus +1 can never alias to a negative value before wrapping.
    logic signed [AW:0] dx_sum;
    logic signed [AW:0] dy_sum;
    wide_t              dx_w;
    wide_t              dy_w;

    assign dx_sum = {x_i[AW-1], x_i} + {cx_i[AW-1], cx_i};
    assign dy_sum = {y_i[AW-1], y_i} + {cy_i[AW-1], cy_i};
    assign dx_w   = wide_t'(dx_sum);
    assign dy_w   = wide_t'(dy_sum);

`ifdef BOUNCEBACK_EN
    wide_t src_lin;
    logic  hit_wall;

    assign src_lin  = wide_t'(y_i) * SIDE_W + wide_t'(x_i);
    assign hit_wall = !in_grid(dx_w, SIDE_W) || !in_grid(dy_w, SIDE_W);

    always_comb begin
        wall_o = hit_wall;
        // A blocked population stays in its own cell.
        addr_o = AW'(hit_wall ? src_lin : (dy_w * SIDE_W + dx_w));
    end
`else
    always_comb begin
        wall_o = 1'b0;
        addr_o = AW'(wrap_coord(dy_w, SIDE_W) * SIDE_W + wrap_coord(dx_w, SIDE_W));
    end
`endif

endmodule : stream_dir_addr

`default_nettype wire

// File: rtl/streaming_unit.sv
// ============================================================================
// Module      : streaming_unit
// Description : Streaming-step address generator for a D2Q9 LBM core on a
//               SIDE_LENGTH x SIDE_LENGTH grid. For one source cell it emits
//               the linear write address for each of the 9 directions after
//               exactly one registered stage. No backpressure.
// Config      : BOUNCEBACK_EN - solid walls instead of periodic wrap;
//               wall_mask reports which directions hit a wall.
// Ports       : clk             rising-edge clock
//               reset           asynchronous active-high reset
//               in_valid        x/y/cx/cy qualify this cycle
//               x, y            source column/row (signed, AW bits)
//               cx, cy          packed velocity slots, slot i = [i*AW +: AW]
//               out_valid       outputs carry a fresh result
//               write_addresses packed destination addresses, same layout
//               coord_err       source x or y was outside 0..SIDE_LENGTH-1
//               wall_mask       bit i: direction i blocked by a wall
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module streaming_unit
    import lbm_pkg::*;
#(
    parameter int GRID_DIM      = 256,
    parameter int SIDE_LENGTH   = GRID_DIM / 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic signed [ADDRESS_WIDTH-1:0]   x,
    input  logic signed [ADDRESS_WIDTH-1:0]   y,
    input  logic signed [Q*ADDRESS_WIDTH-1:0] cx,
    input  logic signed [Q*ADDRESS_WIDTH-1:0] cy,
    output logic                              out_valid,
    output logic        [Q*ADDRESS_WIDTH-1:0] write_addresses,
    output logic                              coord_err,
    output logic        [Q-1:0]               wall_mask
);

    localparam int    AW     = ADDRESS_WIDTH;
    localparam wide_t SIDE_W = wide_t'(SIDE_LENGTH);

    // ------------------------------------------------------------------
    // Next-state (combinational) values
    // ------------------------------------------------------------------
    logic [Q*AW-1:0] addr_d;
    logic [Q-1:0]    wall_d;
    logic            coord_err_d;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic            valid_q;
    logic [Q*AW-1:0] addr_q;
    logic [Q-1:0]    wall_q;
    logic            coord_err_q;

    // One address slice per direction; slots carry no ordering relation.
    generate
        for (genvar i = 0; i < Q; i++) begin : g_dir
            stream_dir_addr #(
                .SIDE_LENGTH (SIDE_LENGTH),
                .AW          (AW)
            ) u_dir (
                .x_i    (x),
                .y_i    (y),
                .cx_i   (cx[i*AW +: AW]),
                .cy_i   (cy[i*AW +: AW]),
                .addr_o (addr_d[i*AW +: AW]),
                .wall_o (wall_d[i])
            );
        end
    endgenerate

    // Source-coordinate range check; addresses are still produced by the
    // normal rule so downstream logic sees a defined value either way.
    assign coord_err_d = !in_grid(wide_t'(x), SIDE_W) || !in_grid(wide_t'(y), SIDE_W);

    // Valid follows in_valid every cycle; data registers only load on a
    // valid input and otherwise keep the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wall_q      <= '0;
            coord_err_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                addr_q      <= addr_d;
                wall_q      <= wall_d;
                coord_err_q <= coord_err_d;
            end
        end
    end

    assign out_valid       = valid_q;
    assign write_addresses = addr_q;
    assign coord_err       = coord_err_q;
    assign wall_mask       = wall_q;

endmodule : streaming_unit

`default_nettype wire

// File: tb/tb_streaming_unit.sv
// ============================================================================
// Module      : tb_streaming_unit
// Description : Self-checking bench for streaming_unit. An abstract model
//               (modulo arithmetic on integers) predicts every output each
//               cycle; directed literal expectations pin the model.
// Config      : BOUNCEBACK_EN selects the solid-wall expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_streaming_unit;

    localparam int Q  = 9;
    localparam int AW = 9;
    localparam int S  = 16;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic signed [AW-1:0]     x = '0;
    logic signed [AW-1:0]     y = '0;
    logic signed [Q*AW-1:0]   cx = '0;
    logic signed [Q*AW-1:0]   cy = '0;
    logic                     out_valid;
    logic        [Q*AW-1:0]   write_addresses;
    logic                     coord_err;
    logic        [Q-1:0]      wall_mask;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Velocity set, index = slot number.
    int CX[9] = '{1, -1, -1, 1, 0, -1, 0, 1, 0};
    int CY[9] = '{1, 1, -1, -1, 1, 0, -1, 0, 0};

    // Hand-computed expectations, index = slot number.
    int E_NW[9]  = '{17, 31, 255, 241, 16, 15, 240, 1, 0};
    int E_MID[9] = '{134, 132, 100, 102, 133, 116, 101, 118, 117};
    int E_SE[9]  = '{0, 14, 238, 224, 15, 254, 239, 240, 255};
    int E_BB[9]  = '{17, 0, 0, 0, 16, 0, 0, 1, 0};

    streaming_unit u_dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .x               (x),
        .y               (y),
        .cx              (cx),
        .cy              (cy),
        .out_valid       (out_valid),
        .write_addresses (write_addresses),
        .coord_err       (coord_err),
        .wall_mask       (wall_mask)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: destination of one population
    // ------------------------------------------------------------------
    function automatic void model_slot(input int xx, input int yy, input int vx, input int vy,
                                       output int addr, output bit wall);
        int dx;
        int dy;
        dx = xx + vx;
        dy = yy + vy;
`ifdef BOUNCEBACK_EN
        if (dx < 0 || dx >= S || dy < 0 || dy >= S) begin
            addr = yy * S + xx;
            wall = 1'b1;
        end else begin
            addr = dy * S + dx;
            wall = 1'b0;
        end
`else
        addr = (((dy % S) + S) % S) * S + (((dx % S) + S) % S);
        wall = 1'b0;
`endif
    endfunction

    int m_addr[9] = '{default: 0};
    bit m_wall[9] = '{default: 1'b0};
    bit m_valid = 1'b0;
    bit m_err = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            for (int i = 0; i < Q; i++) begin
                m_addr[i] <= 0;
                m_wall[i] <= 1'b0;
            end
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_err <= (int'(x) < 0) || (int'(x) >= S) || (int'(y) < 0) || (int'(y) >= S);
                for (int i = 0; i < Q; i++) begin
                    int a;
                    bit w;
                    model_slot(int'(x), int'(y), int'($signed(cx[i*AW +: AW])),
                               int'($signed(cy[i*AW +: AW])), a, w);
                    m_addr[i] <= a;
                    m_wall[i] <= w;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_slots(input string name, input int e[9]);
        for (int i = 0; i < Q; i++) begin
            chk($sformatf("%s slot%0d", name, i), int'(write_addresses[i*AW +: AW]), e[i]);
        end
    endtask

    // Model comparison on every falling edge once the bench is running.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model out_valid", int'(out_valid), int'(m_valid));
            chk("model coord_err", int'(coord_err), int'(m_err));
            for (int i = 0; i < Q; i++) begin
                chk($sformatf("model addr%0d", i), int'(write_addresses[i*AW +: AW]), m_addr[i]);
                chk($sformatf("model wall%0d", i), int'(wall_mask[i]), int'(m_wall[i]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic set_vel(input bit neg);
        for (int i = 0; i < Q; i++) begin
            cx[i*AW +: AW] = AW'(neg ? -CX[i] : CX[i]);
            cy[i*AW +: AW] = AW'(neg ? -CY[i] : CY[i]);
        end
    endtask

    task automatic set_in(input int xx, input int yy, input bit v);
        x        = AW'(xx);
        y        = AW'(yy);
        in_valid = v;
    endtask

    initial begin
        set_vel(1'b0);
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;

        // Reset state
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset coord_err", int'(coord_err), 0);
        chk("reset wall_mask", int'(wall_mask), 0);
        chk("reset addr0", int'(write_addresses[AW-1:0]), 0);
        reset = 1'b0;

        // NW corner
        set_in(0, 0, 1'b1);
        @(negedge clk);
        chk("nw out_valid", int'(out_valid), 1);
`ifdef BOUNCEBACK_EN
        chk_slots("bb nw", E_BB);
        chk("bb nw wall_mask", int'(wall_mask), int'(9'b001101110));
`else
        chk_slots("nw", E_NW);
        chk("nw wall_mask", int'(wall_mask), 0);
`endif

        // Interior cell: identical in both wall modes
        set_in(5, 7, 1'b1);
        @(negedge clk);
        chk_slots("mid", E_MID);
        chk("mid coord_err", int'(coord_err), 0);

        // SE corner
        set_in(15, 15, 1'b1);
        @(negedge clk);
`ifndef BOUNCEBACK_EN
        chk_slots("se", E_SE);
`endif
        chk("se out_valid", int'(out_valid), 1);

        // Out-of-range source column
        set_in(16, 0, 1'b1);
        @(negedge clk);
        chk("err coord_err", int'(coord_err), 1);
        chk("err out_valid", int'(out_valid), 1);

        // Bubble: valid drops, data holds
        set_in(3, 3, 1'b0);
        @(negedge clk);
        chk("bubble out_valid", int'(out_valid), 0);

        // Back-to-back stream with the reversed velocity set
        set_vel(1'b1);
        foreach (E_NW[k]) begin
            set_in((k * 7) % S, (k * 11 + 3) % S, 1'b1);
            @(negedge clk);
            chk("stream out_valid", int'(out_valid), 1);
        end
        set_vel(1'b0);
        set_in(0, 15, 1'b1);
        @(negedge clk);
        set_in(15, 0, 1'b0);
        @(negedge clk);

        // Asynchronous reset while a result is held valid
        set_in(5, 7, 1'b1);
        @(negedge clk);
        chk("pre-reset out_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async out_valid", int'(out_valid), 0);
        chk("async addr8", int'(write_addresses[8*AW +: AW]), 0);
        chk("async coord_err", int'(coord_err), 0);
        chk("async wall_mask", int'(wall_mask), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset idle", int'(out_valid), 0);
        set_in(0, 0, 1'b1);
        @(negedge clk);
        chk("post-reset out_valid", int'(out_valid), 1);
`ifdef BOUNCEBACK_EN
        chk_slots("post-reset bb", E_BB);
`else
        chk_slots("post-reset nw", E_NW);
`endif
        set_in(0, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_streaming_unit

`default_nettype wire
